// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter steering a 16:1 mux: grants one channel per packet,
// drives the mux select, and registers the granted word onto a valid/ready output.
module mux_rr_arbiter #(
    parameter int N  = 16,
    parameter int W  = 33,
    parameter int SW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    input  logic [N-1:0][W-1:0] i,
    output logic [SW-1:0]       s,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        y
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d, s_d, pick;
    logic          found, can_take, xfer;
    int            idx;

    // Output slot is free when empty or draining this cycle.
    assign can_take = !out_valid || out_ready;
    assign busy     = (state_q == LOCK);

    // Per-lane ready decode; never depends on in_valid.
    for (genvar g = 0; g < N; g++) begin : g_rdy
        assign in_ready[g] = (state_q == LOCK) && (s == SW'(g)) && can_take;
    end

    assign xfer = in_valid[s] && in_ready[s];

    // First requester at or after ptr, wrapping N-1 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCK;
                    s_d     = pick;
                end
            end
            LOCK: begin
                if (xfer && i[s][W-1]) begin
                    state_d = IDLE;
                    ptr_d   = (s == SW'(N-1)) ? '0 : s + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            s         <= '0;
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s       <= s_d;
            if (xfer) begin
                y         <= i[s];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a vector table for arbitration/handshake
// basics plus scripted sequences for fairness, packet lock, backpressure and reset.
module tb_mux_rr_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       in_valid;
    logic [15:0]       in_ready;
    logic [15:0][32:0] i;
    logic [3:0]        s;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [32:0]       y;

    int checks   = 0;
    int failures = 0;

    mux_rr_arbiter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .i(i),
        .s(s), .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] iv;
        logic [15:0] lst;
        logic        ordy;
        logic [15:0] e_rdy;
        logic [3:0]  e_s;
        logic        e_busy;
        logic        e_ov;
        logic [32:0] e_y;
    } vec_t;

    vec_t tv[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Table words: channel c carries payload A0+c, last flag from the mask.
    task automatic load_words(input logic [15:0] lst);
        for (int c = 0; c < 16; c++) i[c] = {lst[c], 32'h0000_00A0 + 32'(c)};
    endtask

    initial begin
        //        rst  iv        lst       ordy  e_rdy     s  busy ov  y
        tv[0]  = '{0, 16'hFFFF, 16'hFFFF, 1, 16'h0000,  0, 0, 0, 33'h0_0000_0000};
        tv[1]  = '{1, 16'h0020, 16'h0020, 1, 16'h0000,  5, 1, 0, 33'h0_0000_0000};
        tv[2]  = '{1, 16'h0020, 16'h0020, 1, 16'h0020,  5, 0, 1, 33'h1_0000_00A5};
        tv[3]  = '{1, 16'h0002, 16'h0002, 1, 16'h0000,  1, 1, 0, 33'h1_0000_00A5};
        tv[4]  = '{1, 16'h0002, 16'h0002, 1, 16'h0002,  1, 0, 1, 33'h1_0000_00A1};
        tv[5]  = '{1, 16'h2000, 16'h2000, 0, 16'h0000, 13, 1, 1, 33'h1_0000_00A1};
        tv[6]  = '{1, 16'h2000, 16'h2000, 0, 16'h0000, 13, 1, 1, 33'h1_0000_00A1};
        tv[7]  = '{1, 16'h2000, 16'h2000, 1, 16'h2000, 13, 0, 1, 33'h1_0000_00AD};
        tv[8]  = '{1, 16'h0002, 16'h0002, 1, 16'h0000,  1, 1, 0, 33'h1_0000_00AD};
        tv[9]  = '{1, 16'h0002, 16'h0000, 1, 16'h0002,  1, 1, 1, 33'h0_0000_00A1};
        tv[10] = '{1, 16'h0000, 16'h0000, 1, 16'h0002,  1, 1, 0, 33'h0_0000_00A1};
        tv[11] = '{1, 16'h0001, 16'h0003, 1, 16'h0002,  1, 1, 0, 33'h0_0000_00A1};
        tv[12] = '{1, 16'h0003, 16'h0003, 1, 16'h0002,  1, 0, 1, 33'h1_0000_00A1};
        tv[13] = '{1, 16'h0001, 16'h0001, 1, 16'h0000,  0, 1, 0, 33'h1_0000_00A1};
        tv[14] = '{1, 16'h0001, 16'h0001, 1, 16'h0001,  0, 0, 1, 33'h1_0000_00A0};

        // First reset cycle, all channels requesting.
        rst = 1'b0; in_valid = 16'hFFFF; out_ready = 1'b1; load_words(16'hFFFF);
        tick();

        for (int k = 0; k < 15; k++) begin
            rst = tv[k].rst; in_valid = tv[k].iv; out_ready = tv[k].ordy;
            load_words(tv[k].lst);
            #1;
            chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(tv[k].e_rdy));
            tick();
            chk($sformatf("v%0d_s", k),    64'(s),         64'(tv[k].e_s));
            chk($sformatf("v%0d_busy", k), 64'(busy),      64'(tv[k].e_busy));
            chk($sformatf("v%0d_ov", k),   64'(out_valid), 64'(tv[k].e_ov));
            chk($sformatf("v%0d_y", k),    64'(y),         64'(tv[k].e_y));
        end

        // Fairness: all channels, single-beat packets, from reset.
        rst = 1'b0; in_valid = 16'hFFFF; out_ready = 1'b1; load_words(16'hFFFF);
        tick(); tick();
        rst = 1'b1;
        for (int g = 0; g < 18; g++) begin
            tick();
            chk($sformatf("fair%0d_s", g), 64'(s), 64'(g % 16));
            chk($sformatf("fair%0d_busy", g), 64'(busy), 64'd1);
            tick();
            chk($sformatf("fair%0d_y", g), 64'(y), 64'({1'b1, 32'h0000_00A0 + 32'(g % 16)}));
        end

        // Packet lock + backpressure: move ptr to 3 via a ch2 single beat.
        rst = 1'b0; in_valid = '0; tick(); tick();
        rst = 1'b1;
        i = '0;
        i[2] = {1'b1, 32'h2000_0000};
        in_valid = 16'h0004;
        tick(); tick();
        chk("lk_pre_y", 64'(y), 64'h1_2000_0000);
        in_valid = 16'h000C;
        i[3] = {1'b0, 32'h3000_0000};
        tick();
        chk("lk_grant_s", 64'(s), 64'd3);
        for (int b = 0; b < 2; b++) begin
            i[3] = {1'b0, 32'h3000_0000 + 32'(b)};
            #1;
            chk($sformatf("lk_b%0d_rdy", b), 64'(in_ready), 64'h0008);
            tick();
            chk($sformatf("lk_b%0d_y", b), 64'(y), 64'({1'b0, 32'h3000_0000 + 32'(b)}));
        end
        out_ready = 1'b0;
        i[3] = {1'b0, 32'h3000_0002};
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_rdy", c), 64'(in_ready), 64'h0000);
            tick();
            chk($sformatf("bp%0d_y", c), 64'(y), 64'h0_3000_0001);
            chk($sformatf("bp%0d_ov", c), 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("lk_b2_rdy", 64'(in_ready), 64'h0008);
        tick();
        chk("lk_b2_y", 64'(y), 64'h0_3000_0002);
        i[3] = {1'b1, 32'h3000_0003};
        #1;
        chk("lk_b3_rdy", 64'(in_ready), 64'h0008);
        tick();
        chk("lk_b3_y", 64'(y), 64'h1_3000_0003);
        chk("lk_b3_busy", 64'(busy), 64'd0);
        #1;
        chk("lk_idle_rdy", 64'(in_ready), 64'h0000);
        tick();
        chk("lk_next_s", 64'(s), 64'd2);
        chk("lk_next_ov", 64'(out_valid), 64'd0);
        in_valid = 16'h0004;
        tick();
        chk("lk_ch2_y", 64'(y), 64'h1_2000_0000);

        // Reset mid-packet on beat 2 of a ch5 packet.
        in_valid = 16'h0020;
        i[5] = {1'b0, 32'h5000_0000};
        tick();
        chk("rm_grant_s", 64'(s), 64'd5);
        tick();
        chk("rm_b0_y", 64'(y), 64'h0_5000_0000);
        i[5] = {1'b0, 32'h5000_0001};
        rst = 1'b0;
        tick();
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_ov", 64'(out_valid), 64'd0);
        chk("rm_s", 64'(s), 64'd0);
        chk("rm_y", 64'(y), 64'd0);
        chk("rm_rdy", 64'(in_ready), 64'h0000);
        rst = 1'b1;
        in_valid = 16'h0012;
        i[1] = {1'b1, 32'h1000_0000};
        i[4] = {1'b1, 32'h4000_0000};
        tick();
        chk("rm_next_s", 64'(s), 64'd1);
        tick();
        chk("rm_next_y", 64'(y), 64'h1_1000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
